// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIT   = 2'd1,
        GUARD = 2'd2
    } scan_state_e;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BLANK_NIB = 4'h0;

    function automatic logic nib_is_bcd(input logic [BCD_W-1:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Down-counter for digit-on and guard intervals; tc flags a count of zero.
// Loading takes priority over counting; the count parks at zero.
module seg_refresh_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed BCD display scanner with pending/display double buffering.
// Define SEG_SCAN_LZ_BLANK_EN to darken leading zero digits.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
    input  logic                        bcd_valid,
    output logic                        bcd_ready,
    output logic [BCD_W-1:0]            digit_nib,
    output logic [NUM_DIGITS-1:0]       digit_sel_n,
    output logic                        frame_start
);

    localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYC) ?
                             REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W = $clog2(MAX_CYC);
    localparam int IW    = $clog2(NUM_DIGITS);
    localparam int DW    = BCD_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0] LIT_LOAD   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(BLANK_CYC - 1);
    localparam logic [IW-1:0]    LAST_IDX   = IW'(NUM_DIGITS - 1);

    scan_state_e      state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [DW-1:0]    disp_q, disp_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_cnt;
    logic             tmr_tc;

    logic             xfer;
    logic             consume;
    logic [IW-1:0]    idx_next;
    logic [BCD_W-1:0] cur_nib;
    logic [NUM_DIGITS-1:0] lz_dark;
    logic             dark;

    seg_refresh_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .cnt      (tmr_cnt),
        .tc       (tmr_tc)
    );

    assign bcd_ready = !pend_full_q;
    assign xfer      = bcd_valid && bcd_ready;
    assign idx_next  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    // Next-state: slot sequencing and frame-boundary consumption
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmr_load     = 1'b0;
        tmr_load_val = LIT_LOAD;
        consume      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_full_q) begin
                    state_d  = LIT;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    consume  = 1'b1;
                end
            end
            LIT: begin
                if (tmr_tc) begin
                    state_d      = GUARD;
                    tmr_load     = 1'b1;
                    tmr_load_val = GUARD_LOAD;
                end
            end
            GUARD: begin
                if (tmr_tc) begin
                    state_d  = LIT;
                    idx_d    = idx_next;
                    tmr_load = 1'b1;
                    consume  = (idx_next == '0) && pend_full_q;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        if (consume) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = bcd_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            disp_q      <= disp_d;
        end
    end

    always_comb begin
        cur_nib = BLANK_NIB;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib = disp_q[i*BCD_W +: BCD_W];
            end
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    // A digit is a leading zero if it and every higher digit are zero
    always_comb begin : lz_p
        logic run;
        run     = 1'b1;
        lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run        = run && (disp_q[i*BCD_W +: BCD_W] == 4'h0);
            lz_dark[i] = run;
        end
    end
`else
    assign lz_dark = '0;
`endif

    always_comb begin
        dark = !nib_is_bcd(cur_nib);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i) && lz_dark[i]) begin
                dark = 1'b1;
            end
        end
    end

    // Outputs decode straight from reset-cleared flops so reset blanks at once
    always_comb begin
        digit_sel_n = '1;
        digit_nib   = BLANK_NIB;
        frame_start = 1'b0;
        if (state_q == LIT) begin
            digit_nib   = cur_nib;
            frame_start = (idx_q == '0) && (tmr_cnt == LIT_LOAD);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IW'(i) && !dark) begin
                    digit_sel_n[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: slot-time model plus directed checks.
// Expectations follow SEG_SCAN_LZ_BLANK_EN when it is defined.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int B     = 2;
    localparam int SLOT  = R + B;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic        bcd_valid = 1'b0;
    logic        bcd_ready;
    logic [3:0]  digit_nib;
    logic [3:0]  digit_sel_n;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYC   (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd_in      (bcd_in),
        .bcd_valid   (bcd_valid),
        .bcd_ready   (bcd_ready),
        .digit_nib   (digit_nib),
        .digit_sel_n (digit_sel_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib_of(input logic [15:0] v, input int i);
        return 4'(v >> (4 * i));
    endfunction

    function automatic bit slot_dark(input logic [15:0] v, input int i);
        if (nib_of(v, i) > 4'd9) return 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (i > 0 && (v >> (4 * i)) == 16'h0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Model: time since first frame start decides slot and lit/guard phase
    bit          m_started;
    int          m_t;
    logic [15:0] m_pend;
    bit          m_pend_full;
    logic [15:0] m_shown;

    always @(negedge clk) begin
        int   slot;
        int   off;
        logic [3:0] e_sel;
        logic [3:0] e_nib;
        bit   e_fs;
        bit   xfer;
        bit   cons;
        if (!rst_n) begin
            m_started   = 0;
            m_t         = 0;
            m_pend      = 16'h0;
            m_pend_full = 0;
            m_shown     = 16'h0;
            check("rst_sel", digit_sel_n, 4'hF);
            check("rst_nib", digit_nib, 4'h0);
            check("rst_ready", bcd_ready, 1'b1);
            check("rst_fs", frame_start, 1'b0);
        end else begin
            e_sel = 4'hF;
            e_nib = 4'h0;
            e_fs  = 0;
            if (m_started) begin
                slot = m_t / SLOT;
                off  = m_t % SLOT;
                if (off < R) begin
                    e_nib = nib_of(m_shown, slot);
                    e_fs  = (m_t == 0);
                    if (!slot_dark(m_shown, slot))
                        e_sel = 4'(~(4'b0001 << slot));
                end
            end
            check("mdl_sel", digit_sel_n, e_sel);
            check("mdl_nib", digit_nib, e_nib);
            check("mdl_fs", frame_start, e_fs);
            check("mdl_ready", bcd_ready, !m_pend_full);
            xfer = bcd_valid && !m_pend_full;
            cons = 0;
            if (!m_started) begin
                if (m_pend_full) begin
                    m_started = 1;
                    m_t       = 0;
                    cons      = 1;
                end
            end else begin
                m_t = (m_t + 1) % FRAME;
                cons = (m_t == 0) && m_pend_full;
            end
            if (cons) begin
                m_shown     = m_pend;
                m_pend_full = 0;
            end
            if (xfer) begin
                m_pend      = bcd_in;
                m_pend_full = 1;
            end
        end
    end

    task automatic send(input logic [15:0] v);
        bit rdy_pre;
        int n = 0;
        bcd_in    = v;
        bcd_valid = 1'b1;
        forever begin
            rdy_pre = bcd_ready;
            @(posedge clk);
            #1;
            if (rdy_pre) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        bcd_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        if (!frame_start) check("fs_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_sel", digit_sel_n, 4'hF);
        check("idle_ready", bcd_ready, 1'b1);

        send(16'h1234);
        @(negedge clk);
        check("p1_ready", bcd_ready, 1'b0);
        check("p1_sel", digit_sel_n, 4'hF);
        @(negedge clk);
        check("d0_fs", frame_start, 1'b1);
        check("d0_sel", digit_sel_n, 4'b1110);
        check("d0_nib", digit_nib, 4'h4);
        repeat (4) @(negedge clk);
        check("g0_sel", digit_sel_n, 4'hF);
        repeat (2) @(negedge clk);
        check("d1_sel", digit_sel_n, 4'b1101);
        check("d1_nib", digit_nib, 4'h3);
        repeat (18) @(negedge clk);
        check("f2_fs", frame_start, 1'b1);
        check("f2_nib", digit_nib, 4'h4);

        send(16'h0056);
        @(negedge clk);
        check("mid_ready", bcd_ready, 1'b0);
        repeat (17) @(negedge clk);
        check("old_d3_sel", digit_sel_n, 4'b0111);
        check("old_d3_nib", digit_nib, 4'h1);
        check("old_d3_ready", bcd_ready, 1'b0);
        repeat (6) @(negedge clk);
        check("new_fs", frame_start, 1'b1);
        check("new_d0_nib", digit_nib, 4'h6);
        check("new_ready", bcd_ready, 1'b1);
        repeat (6) @(negedge clk);
        check("new_d1_sel", digit_sel_n, 4'b1101);
        check("new_d1_nib", digit_nib, 4'h5);

        send(16'h0007);
        wait_fs();
        check("z_d0_sel", digit_sel_n, 4'b1110);
        check("z_d0_nib", digit_nib, 4'h7);
        repeat (6) @(negedge clk);
`ifdef SEG_SCAN_LZ_BLANK_EN
        check("z_d1_sel", digit_sel_n, 4'hF);
`else
        check("z_d1_sel", digit_sel_n, 4'b1101);
`endif
        check("z_d1_nib", digit_nib, 4'h0);

        send(16'h12C4);
        wait_fs();
        check("c_d0_sel", digit_sel_n, 4'b1110);
        check("c_d0_nib", digit_nib, 4'h4);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("c_d1_dark", digit_sel_n, 4'hF);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("c_d2_sel", digit_sel_n, 4'b1011);
        check("c_d2_nib", digit_nib, 4'h2);

        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", digit_sel_n, 4'hF);
        check("arst_nib", digit_nib, 4'h0);
        check("arst_ready", bcd_ready, 1'b1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_sel", digit_sel_n, 4'hF);
        check("post_ready", bcd_ready, 1'b1);

        send(16'h1234);
        @(negedge clk);
        @(negedge clk);
        check("re_fs", frame_start, 1'b1);
        check("re_sel", digit_sel_n, 4'b1110);
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, 2..8.
REQ-002 Parameter REFRESH_DIV, default 1000: clock cycles each digit is lit, >=2.
REQ-003 Parameter BLANK_CYC, default 16: all-off guard cycles between digits, >=1.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 bcd_in  input  4*NUM_DIGITS  packed BCD value, digit 0 = bits [3:0] (least significant).
REQ-007 bcd_valid  input  1  bcd_in is valid this cycle.
REQ-008 bcd_ready  output  1  block can accept bcd_in.
REQ-009 digit_nib  output  4  BCD nibble for the segment decoder.
REQ-010 digit_sel_n  output  NUM_DIGITS  active-low digit enables; at most one bit low at any time.
REQ-011 frame_start  output  1  one-cycle pulse when digit 0 is selected.

Function
REQ-012 Transfer occurs on any cycle with bcd_valid=1 and bcd_ready=1; bcd_in is captured into a pending register.
REQ-013 bcd_ready SHALL be 0 while the pending register holds an unconsumed value, and 1 otherwise.
REQ-014 The pending value moves into the display register only at a frame boundary: the first cycle of digit 0, or directly from IDLE; no mid-frame tearing.
REQ-015 If consumption and a new transfer coincide in one cycle, the new value enters pending and bcd_ready stays 0.
REQ-016 States: IDLE (display off, no value yet), LIT (one digit driven), GUARD (all digits off).
REQ-017 IDLE -> LIT(digit 0) the cycle after the pending register becomes full; display register is loaded on that transition.
REQ-018 LIT(i) lasts exactly REFRESH_DIV cycles, then GUARD for exactly BLANK_CYC cycles, then LIT((i+1) mod NUM_DIGITS).
REQ-019 In LIT(i), digit_sel_n[i]=0 and digit_nib = display nibble i; in GUARD and IDLE, digit_sel_n all 1 and digit_nib=0.
REQ-020 A nibble >9 keeps its digit_sel_n bit high for that slot (digit dark); timing is unchanged.
REQ-021 frame_start pulses on the first cycle of every LIT(0).
REQ-022 Once out of IDLE, scanning never stops; only reset returns to IDLE.

Reset
REQ-023 While rst_n=0: state IDLE, digit_sel_n all 1, digit_nib=0, bcd_ready=1, frame_start=0, pending and display registers 0, counters 0.
REQ-024 Reset asserted mid-digit SHALL turn all digits off immediately (asynchronously), and any pending value is lost.

Configuration
REQ-025 Macro SEG_SCAN_LZ_BLANK_EN defined: leading zero digits (most significant downward, up to but not including digit 0) are dark in their LIT slot; slot timing is unchanged.
REQ-026 Macro SEG_SCAN_LZ_BLANK_EN undefined: all valid digits are lit, zeros included.

Structure
REQ-027 Package seg_scan_pkg holds the state enum (IDLE, LIT, GUARD), BCD_W=4, and the blank nibble constant 4'h0.
REQ-028 Sub-module seg_refresh_timer: a down-counter loaded with REFRESH_DIV-1 or BLANK_CYC-1 that flags terminal count; the FSM and handshake stay in seg_scan_ctrl.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=2)
REQ-029 Reset release with no valid -> digit_sel_n=4'hF and bcd_ready=1 for 100 cycles.
REQ-030 Send 16'h1234 -> next cycle LIT(0) with nib 4, sel 4'b1110 for 4 cycles, then 4'hF for 2 cycles, then nib 3 with sel 4'b1101; frame period is 24 cycles.
REQ-031 Send 16'h0056 mid-frame while showing 16'h1234 -> bcd_ready=0 until the next LIT(0); the current frame completes as 1234; the next frame shows 0056.
REQ-032 Send 16'h0007 with the macro defined -> only the digit 0 slot lit (nib 7); macro undefined -> all four slots lit with 0,0,0,7.
REQ-033 Send 16'h12C4 -> the digit 1 slot stays dark (sel 4'hF for its 4 cycles); the other digits show normally.
REQ-034 Pulse rst_n low during LIT(2) -> sel 4'hF in the same cycle; after release the block returns to IDLE and bcd_ready=1.
